// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the UART program loader:
//               frame sync byte, field widths, loader and receiver states.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Frame framing constants
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
    localparam int         c_DATA_W    = 8;
    localparam int         c_LEN_W     = 16;
    localparam int         c_ADDR_W    = 16;

    // Loader frame-parser states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // UART receiver bit-level states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A frame is "in progress" from the sync byte until the checksum byte
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN_H) || (s == ST_LEN_L) ||
               (s == ST_DATA)  || (s == ST_CSUM);
    endfunction

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first. Synchronises rx, detects the
//               falling start edge, re-checks start at half a bit, samples
//               data and stop bits at mid-bit. Emits one-cycle valid or
//               frame_err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    rx_state_t          rx_state_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               frame_err_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-timing state machine; valid/frame_err are one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    // Only a high-to-low transition starts a byte, so a line
                    // stuck low after a bad stop bit cannot retrigger
                    if (prev_q && !sync2_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == c_HALF) begin
                        cnt_q      <= '0;
                        // High at mid start bit means a glitch, not a byte
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == c_FULL) begin
                        cnt_q     <= '0;
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == c_FULL) begin
                        cnt_q      <= '0;
                        rx_state_q <= RX_IDLE;
                        if (sync2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule : uart_rx
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : UART boot loader. Parses frames of the form
//               A5, LEN_H, LEN_L, LEN data bytes, CSUM and writes the data
//               bytes to consecutive memory addresses from BASE_ADDR. Holds
//               the CPU in reset until a frame with a good checksum lands.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               CLKS_PER_BIT   = 234,
    parameter logic [15:0]      BASE_ADDR      = 16'h0000,
    parameter int               TIMEOUT_CYCLES = 2_700_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    output logic                mem_we,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [31:0] c_TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [7:0]          w_rx_data;
    logic                w_rx_valid;
    logic                w_rx_ferr;
    logic                w_timeout;

    state_t              state_q;
    state_t              state_d;
    logic [c_LEN_W-1:0]  len_q;
    logic [c_LEN_W-1:0]  idx_q;
    logic [7:0]          csum_q;
    logic [31:0]         tmo_q;

    logic [c_ADDR_W-1:0] mem_addr_q;
    logic [c_DATA_W-1:0] mem_wdata_q;
    logic                mem_we_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (w_rx_data),
        .valid     (w_rx_valid),
        .frame_err (w_rx_ferr)
    );

    // Inter-byte silence has run too long; a byte arriving this cycle wins
    assign w_timeout = (tmo_q >= c_TMO_LIMIT) && !w_rx_valid;

    // Next frame-parser state from the received byte stream
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_rx_valid && (w_rx_data == c_SYNC_BYTE)) state_d = ST_LEN_H;
            end
            ST_LEN_H: begin
                if (w_rx_valid) state_d = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (w_rx_valid) begin
                    state_d = ({len_q[15:8], w_rx_data} == 16'd0) ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_rx_valid && (idx_q == len_q - 16'd1)) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_rx_valid) state_d = (w_rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                if (w_rx_valid && (w_rx_data == c_SYNC_BYTE)) state_d = ST_LEN_H;
            end
            default: state_d = ST_IDLE;
        endcase
        // Line errors and stalls abort any frame in progress
        if (is_busy(state_q) && (w_rx_ferr || w_timeout)) begin
            state_d = ST_ERR;
        end
    end

    // State register, frame bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;

            // Status flags follow the next state so they change on entry
            cpu_rst_q <= (state_d != ST_DONE);
            busy_q    <= is_busy(state_d);
            done_q    <= (state_d == ST_DONE);
            err_q     <= (state_d == ST_ERR);

            if (w_rx_valid || !is_busy(state_q)) begin
                tmo_q <= '0;
            end else if (tmo_q != 32'hFFFF_FFFF) begin
                tmo_q <= tmo_q + 32'd1;
            end

            if (w_rx_valid) begin
                case (state_q)
                    ST_IDLE, ST_ERR: begin
                        if (w_rx_data == c_SYNC_BYTE) begin
                            len_q  <= '0;
                            idx_q  <= '0;
                            csum_q <= '0;
                        end
                    end
                    ST_LEN_H: len_q[15:8] <= w_rx_data;
                    ST_LEN_L: len_q[7:0]  <= w_rx_data;
                    ST_DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= w_rx_data;
                        mem_addr_q  <= BASE_ADDR + idx_q;
                        csum_q      <= csum_q + w_rx_data;
                        idx_q       <= idx_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : prog_loader
`default_nettype wire
